// File: rtl/tft_spi_engine_pkg.sv
// Shared types and the built-in init script for the TFT SPI engine.
package tft_spi_engine_pkg;

    localparam int unsigned EntryW = 18;

    typedef enum logic [1:0] {
        RomCmd = 2'b00,
        RomDat = 2'b01,
        RomDly = 2'b10,
        RomEnd = 2'b11
    } rom_type_e;

    typedef enum logic [2:0] {
        StPrst,
        StPwait,
        StFetch,
        StShift,
        StDelay,
        StDone,
        StIdle,
        StGap
    } state_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Entry = {type, arg}; unlisted addresses read as END.
    function automatic logic [EntryW-1:0] init_rom_entry(input int unsigned addr);
        case (addr)
            0:       return {RomCmd, 16'h0011};
            1:       return {RomDly, 16'd3};
            2:       return {RomDat, 16'h00A5};
            default: return {RomEnd, 16'h0000};
        endcase
    endfunction

endpackage

// File: rtl/tft_spi_engine_rom.sv
// Init-script ROM with a registered read port (one cycle of latency).
module tft_spi_engine_rom
    import tft_spi_engine_pkg::*;
#(
    parameter int unsigned ROM_AW = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ROM_AW-1:0] addr_i,
    output logic [EntryW-1:0] data_o
);

    logic [EntryW-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= init_rom_entry(32'(addr_i));
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/tft_spi_engine.sv
// SPI master for the TFT panel: reset pulse, ROM-driven init script, then host word stream.
module tft_spi_engine
    import tft_spi_engine_pkg::*;
#(
    parameter int unsigned PIX_W      = 16,
    parameter int unsigned INIT_DIV   = 2500,
    parameter int unsigned WORK_DIV   = 5,
    parameter int unsigned DELAY_UNIT = 50000,
    parameter int unsigned RST_LOW    = 500000,
    parameter int unsigned RST_WAIT   = 6000000,
    parameter int unsigned ROM_AW     = 7,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic             MasterCLK,
    input  logic             MasterRSTn,
    input  logic [PIX_W-1:0] tx_data,
    input  logic             tx_rs,
    input  logic             tx_wide,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             SPI_MOSI,
    output logic             SPI_CLK,
    output logic             SPI_CS,
    output logic             RS,
    output logic             RST,
    output logic             init_done,
    output logic             busy
);

    localparam int unsigned DlyW       = 16 + $clog2(DELAY_UNIT);
    localparam int unsigned GapInit    = CS_GAP * INIT_DIV;
    localparam int unsigned GapWork    = CS_GAP * WORK_DIV;
    localparam int unsigned CntW       = max2(max2(DlyW, $clog2(RST_LOW + 1)),
                                              max2($clog2(RST_WAIT + 1),
                                                   $clog2(max2(GapInit, GapWork) + 1)));
    localparam int unsigned DivW       = $clog2(max2(INIT_DIV, WORK_DIV) + 1);
    localparam int unsigned HalfW      = $clog2(2 * PIX_W + 1);
    localparam int unsigned RstLowLoad = (RST_LOW > 0) ? RST_LOW - 1 : 0;
    // FETCH supplies the last cycle of the post-reset wait.
    localparam int unsigned PwaitLoad  = (RST_WAIT > 1) ? RST_WAIT - 2 : 0;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic [HalfW-1:0]  half_q, half_d;
    logic [PIX_W-1:0]  shreg_q, shreg_d;
    logic              rs_q, rs_d;
    logic              wide_q, wide_d;
    logic              phase_init_q, phase_init_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic              init_done_q, init_done_d;

    logic [EntryW-1:0] rom_data;
    rom_type_e         rom_type;
    logic [15:0]       rom_arg;
    logic [DivW-1:0]   div_reload;
    logic [HalfW-1:0]  half_last;
    logic [CntW-1:0]   gap_len;

    tft_spi_engine_rom #(
        .ROM_AW(ROM_AW)
    ) u_rom (
        .clk_i (MasterCLK),
        .rst_ni(MasterRSTn),
        .addr_i(addr_q),
        .data_o(rom_data)
    );

    assign rom_type   = rom_type_e'(rom_data[EntryW-1:16]);
    assign rom_arg    = rom_data[15:0];
    assign div_reload = phase_init_q ? DivW'(INIT_DIV - 1) : DivW'(WORK_DIV - 1);
    assign half_last  = wide_q ? HalfW'(2 * PIX_W) : HalfW'(16);
    assign gap_len    = phase_init_q ? CntW'(GapInit) : CntW'(GapWork);

    always_ff @(posedge MasterCLK or negedge MasterRSTn) begin
        if (!MasterRSTn) begin
            state_q      <= StPrst;
            cnt_q        <= CntW'(RstLowLoad);
            div_cnt_q    <= '0;
            half_q       <= '0;
            shreg_q      <= '0;
            rs_q         <= 1'b0;
            wide_q       <= 1'b0;
            phase_init_q <= 1'b1;
            addr_q       <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_cnt_q    <= div_cnt_d;
            half_q       <= half_d;
            shreg_q      <= shreg_d;
            rs_q         <= rs_d;
            wide_q       <= wide_d;
            phase_init_q <= phase_init_d;
            addr_q       <= addr_d;
            init_done_q  <= init_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_cnt_d    = div_cnt_q;
        half_d       = half_q;
        shreg_d      = shreg_q;
        rs_d         = rs_q;
        wide_d       = wide_q;
        phase_init_d = phase_init_q;
        addr_d       = addr_q;
        init_done_d  = init_done_q;
        unique case (state_q)
            StPrst: begin
                if (cnt_q == '0) begin
                    state_d = StPwait;
                    cnt_d   = CntW'(PwaitLoad);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StPwait: begin
                if (cnt_q == '0) state_d = StFetch;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StFetch: begin
                addr_d = addr_q + ROM_AW'(1);
                if (rom_type == RomEnd || addr_q == '1) begin
                    state_d = StDone;
                end else if (rom_type == RomDly) begin
                    state_d = StDelay;
                    cnt_d   = CntW'(rom_arg) * CntW'(DELAY_UNIT);
                end else begin
                    state_d      = StShift;
                    shreg_d      = PIX_W'(rom_arg[7:0]) << (PIX_W - 8);
                    rs_d         = (rom_type == RomDat);
                    wide_d       = 1'b0;
                    phase_init_d = 1'b1;
                    div_cnt_d    = DivW'(INIT_DIV - 1);
                    half_d       = '0;
                end
            end
            StDelay: begin
                // A zero-length delay still spends this one cycle.
                if (cnt_q <= CntW'(1)) state_d = StFetch;
                else                   cnt_d   = cnt_q - CntW'(1);
            end
            StShift: begin
                if (div_cnt_q != '0) begin
                    div_cnt_d = div_cnt_q - DivW'(1);
                end else begin
                    div_cnt_d = div_reload;
                    if (half_q == half_last) begin
                        // The IDLE/FETCH cycle that follows is the last CS-high gap cycle.
                        if (gap_len > CntW'(1)) begin
                            state_d = StGap;
                            cnt_d   = gap_len - CntW'(2);
                        end else begin
                            state_d = phase_init_q ? StFetch : StIdle;
                        end
                    end else begin
                        half_d = half_q + HalfW'(1);
                        if (half_q[0]) shreg_d = shreg_q << 1;
                    end
                end
            end
            StGap: begin
                if (cnt_q == '0) state_d = phase_init_q ? StFetch : StIdle;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StDone: begin
                state_d     = StIdle;
                init_done_d = 1'b1;
            end
            StIdle: begin
                if (init_done_q && tx_valid) begin
                    state_d      = StShift;
                    shreg_d      = tx_wide ? tx_data : (PIX_W'(tx_data[7:0]) << (PIX_W - 8));
                    rs_d         = tx_rs;
                    wide_d       = tx_wide;
                    phase_init_d = !init_done_q;
                    div_cnt_d    = init_done_q ? DivW'(WORK_DIV - 1) : DivW'(INIT_DIV - 1);
                    half_d       = '0;
                end
            end
            default: state_d = StPrst;
        endcase
    end

    always_comb begin
        SPI_CS    = (state_q != StShift);
        SPI_CLK   = (state_q == StShift) && half_q[0];
        SPI_MOSI  = (state_q == StShift) && shreg_q[PIX_W-1];
        RS        = rs_q;
        RST       = (state_q != StPrst);
        busy      = (state_q == StShift) || (state_q == StGap);
        tx_ready  = (state_q == StIdle) && init_done_q && !busy;
        init_done = init_done_q;
    end

endmodule

// File: tb/tb_tft_spi_engine.sv
// Randomized bench: decodes SPI frames off the pins and compares them with a frame-level model.
module tb_tft_spi_engine;

    localparam int unsigned PixW      = 16;
    localparam int unsigned InitDiv   = 2;
    localparam int unsigned WorkDiv   = 1;
    localparam int unsigned DelayUnit = 4;
    localparam int unsigned RstLow    = 8;
    localparam int unsigned RstWait   = 10;
    localparam int unsigned RomAw     = 7;
    localparam int unsigned CsGap     = 2;
    localparam int unsigned DlyArg    = 3;

    typedef struct {
        logic        rs;
        int          nbits;
        logic [31:0] data;
        int          div;
        int          gap;
    } frame_t;

    frame_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int viol   = 0;
    int cyc    = 0;

    logic            clk, rst_n;
    logic [PixW-1:0] tx_data;
    logic            tx_rs, tx_wide, tx_valid, tx_ready;
    logic            spi_mosi, spi_clk, spi_cs, rs, rst, init_done, busy;

    tft_spi_engine #(
        .PIX_W     (PixW),
        .INIT_DIV  (InitDiv),
        .WORK_DIV  (WorkDiv),
        .DELAY_UNIT(DelayUnit),
        .RST_LOW   (RstLow),
        .RST_WAIT  (RstWait),
        .ROM_AW    (RomAw),
        .CS_GAP    (CsGap)
    ) dut (
        .MasterCLK (clk),
        .MasterRSTn(rst_n),
        .tx_data   (tx_data),
        .tx_rs     (tx_rs),
        .tx_wide   (tx_wide),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .SPI_MOSI  (spi_mosi),
        .SPI_CLK   (spi_clk),
        .SPI_CS    (spi_cs),
        .RS        (rs),
        .RST       (rst),
        .init_done (init_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Init script frames; the DAT frame follows the delay, the CS gap and its own ROM fetch.
    task automatic push_init_frames();
        exp_q.push_back('{rs: 1'b0, nbits: 8, data: 32'h11, div: InitDiv, gap: -1});
        exp_q.push_back('{rs: 1'b1, nbits: 8, data: 32'hA5, div: InitDiv,
                          gap: DlyArg * DelayUnit + CsGap * InitDiv + 1});
    endtask

    task automatic send_word(input logic [PixW-1:0] d, input logic r, input logic w,
                             output int acc);
        int waited;
        tx_data  = d;
        tx_rs    = r;
        tx_wide  = w;
        tx_valid = 1'b1;
        waited   = 0;
        while (!tx_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready) begin
            check_eq("accept_timeout", 32'(tx_ready), 32'd1);
            acc = -1;
        end else begin
            acc = cyc;
            check_eq("init_done_at_accept", 32'(init_done), 32'd1);
            exp_q.push_back('{rs: r, nbits: w ? PixW : 8,
                              data: w ? 32'(d) : 32'(d[7:0]), div: WorkDiv, gap: -1});
        end
        @(negedge clk);
        check_eq("ready_drop", 32'(tx_ready), 32'd0);
    endtask

    // Pin-level frame decoder.
    initial begin
        logic        in_frame, have_prev, sclk_prev, rs0;
        int          nb, low_len, gap, gap_before;
        logic [31:0] bits;
        frame_t      e;
        in_frame   = 1'b0;
        have_prev  = 1'b0;
        sclk_prev  = 1'b0;
        rs0        = 1'b0;
        nb         = 0;
        low_len    = 0;
        gap        = 0;
        gap_before = -1;
        bits       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame  = 1'b0;
                have_prev = 1'b0;
            end else if (!spi_cs) begin
                if (!in_frame) begin
                    in_frame   = 1'b1;
                    nb         = 0;
                    bits       = '0;
                    low_len    = 0;
                    rs0        = rs;
                    gap_before = have_prev ? gap : -1;
                end
                low_len++;
                if (rs !== rs0 || !busy) viol++;
                if (spi_clk && !sclk_prev) begin
                    bits = {bits[30:0], spi_mosi};
                    nb++;
                end
            end else begin
                if (spi_clk || spi_mosi) viol++;
                if (in_frame) begin
                    in_frame  = 1'b0;
                    have_prev = 1'b1;
                    gap       = 1;
                    if (exp_q.size() == 0) begin
                        check_eq("extra_frame", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("frm_rs", 32'(rs0), 32'(e.rs));
                        check_eq("frm_bits", 32'(nb), 32'(e.nbits));
                        check_eq("frm_data", bits, e.data);
                        check_eq("frm_cs_low", 32'(low_len), 32'((2 * e.nbits + 1) * e.div));
                        if (e.gap >= 0 && gap_before >= 0)
                            check_eq("frm_gap", 32'(gap_before), 32'(e.gap));
                        if (gap_before >= 0 && gap_before < CsGap * e.div) viol++;
                    end
                end else begin
                    gap++;
                end
            end
            if (tx_ready && (!init_done || busy)) viol++;
            sclk_prev = rst_n ? spi_clk : 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int              acc, prev_acc, prev_bits, n, k;
        logic            r, w, sclk_prev;
        logic [PixW-1:0] d;
        frame_t          dropped;
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_rs    = 1'b0;
        tx_wide  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_cs", 32'(spi_cs), 32'd1);
        check_eq("rst_sclk", 32'(spi_clk), 32'd0);
        check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
        check_eq("rst_rs", 32'(rs), 32'd0);
        check_eq("rst_rst", 32'(rst), 32'd0);
        check_eq("rst_ready", 32'(tx_ready), 32'd0);
        check_eq("rst_init_done", 32'(init_done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);

        push_init_frames();
        // Host word offered long before init completes; it must wait for init_done.
        tx_data  = 16'hF800;
        tx_rs    = 1'b1;
        tx_wide  = 1'b1;
        tx_valid = 1'b1;
        rst_n    = 1'b1;
        n = 0;
        while (!rst && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check_eq("rst_low_cycles", 32'(n), 32'(RstLow));
        n = 0;
        while (spi_cs && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check_eq("rst_high_to_cs", 32'(n), 32'(RstWait));
        check_eq("init_done_early", 32'(init_done), 32'd0);

        send_word(16'hF800, 1'b1, 1'b1, prev_acc);
        prev_bits = 16;
        send_word(16'h002C, 1'b0, 1'b0, acc);
        check_eq("spacing", 32'(acc - prev_acc), 32'((2 * prev_bits + 1 + CsGap) * WorkDiv));
        prev_acc  = acc;
        prev_bits = 8;

        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 3; i++) begin
                d = PixW'($urandom);
                r = 1'($urandom_range(0, 1));
                w = 1'($urandom_range(0, 1));
                send_word(d, r, w, acc);
                if (i > 0 || b == 0)
                    check_eq("spacing", 32'(acc - prev_acc),
                             32'((2 * prev_bits + 1 + CsGap) * WorkDiv));
                prev_acc  = acc;
                prev_bits = w ? PixW : 8;
            end
            tx_valid = 1'b0;
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        // Abort a wide frame at its fifth SCLK rise.
        send_word(PixW'($urandom), 1'b1, 1'b1, acc);
        k = 0;
        n = 0;
        sclk_prev = spi_clk;
        while (k < 5 && n < 200) begin
            @(negedge clk);
            n++;
            if (spi_clk && !sclk_prev) k++;
            sclk_prev = spi_clk;
        end
        check_eq("bit5_reached", 32'(k), 32'd5);
        #2 rst_n = 1'b0;
        tx_valid = 1'b0;
        #1;
        check_eq("mid_rst_cs", 32'(spi_cs), 32'd1);
        check_eq("mid_rst_sclk", 32'(spi_clk), 32'd0);
        check_eq("mid_rst_rst", 32'(rst), 32'd0);
        check_eq("mid_rst_ready", 32'(tx_ready), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        dropped = exp_q.pop_back();
        repeat (3) @(negedge clk);
        check_eq("mid_rst_init_done", 32'(init_done), 32'd0);
        push_init_frames();
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reinit_done", 32'(init_done), 32'd1);

        send_word(PixW'($urandom), 1'b0, 1'b0, acc);
        tx_valid = 1'b0;
        n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("final_idle", 32'(tx_ready), 32'd1);
        check_eq("frames_left", 32'(exp_q.size()), 32'd0);
        check_eq("protocol_violations", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
